// File: rtl/uart_rx_fifo.sv
// rtl/uart_rx_fifo.sv - UART receiver feeding a first-word-fall-through byte FIFO.
// Defining UART_RX_PARITY_EN switches the frame from 8N1 to 8E1.
module uart_rx_fifo #(
    parameter int CLK_HZ     = 50000000,
    parameter int BAUD       = 115200,
    parameter int DEPTH_LOG2 = 4
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic       RX,
    output logic [7:0] FIFO_OUT,
    output logic       FIFO_V_N,
    input  logic       FIFO_RD,
    output logic       OVERRUN,
    output logic       FRAME_ERR
);
    localparam int CPB   = CLK_HZ / BAUD;
    localparam int HALF  = CPB / 2;
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int CW    = $clog2(CPB + 1);
    localparam int NW    = DEPTH_LOG2 + 1;

`ifdef UART_RX_PARITY_EN
    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_BREAK} state_t;
`else
    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP, S_BREAK} state_t;
`endif

    state_t          state;
    logic            rx_meta;
    logic            rxs;
    logic            rxs_d;
    logic [CW-1:0]   baud_cnt;
    logic [2:0]      bit_cnt;
    logic [7:0]      shreg;
    logic            push;
    logic [7:0]      push_data;
    logic            frame_err;
    logic            baud_tick;
`ifdef UART_RX_PARITY_EN
    logic            par_bit;
`endif

    assign baud_tick = (baud_cnt == CW'(1));

    // baud_cnt is a down counter; the sample point is the cycle it reads 1.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            rx_meta   <= 1'b1;
            rxs       <= 1'b1;
            rxs_d     <= 1'b1;
            state     <= S_IDLE;
            baud_cnt  <= '0;
            bit_cnt   <= '0;
            shreg     <= '0;
            push      <= 1'b0;
            push_data <= '0;
            frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bit   <= 1'b0;
`endif
        end else begin
            rx_meta   <= RX;
            rxs       <= rx_meta;
            rxs_d     <= rxs;
            push      <= 1'b0;
            frame_err <= 1'b0;
            case (state)
                S_IDLE: begin
                    baud_cnt <= '0;
                    if (rxs_d && !rxs) begin
                        state    <= S_START;
                        baud_cnt <= CW'(HALF);
                    end
                end
                S_START: begin
                    if (baud_tick) begin
                        if (!rxs) begin
                            state    <= S_DATA;
                            baud_cnt <= CW'(CPB);
                            bit_cnt  <= '0;
                        end else begin
                            state    <= S_IDLE;
                            baud_cnt <= '0;
                        end
                    end else begin
                        baud_cnt <= baud_cnt - CW'(1);
                    end
                end
                S_DATA: begin
                    if (baud_tick) begin
                        shreg    <= {rxs, shreg[7:1]};
                        baud_cnt <= CW'(CPB);
                        if (bit_cnt == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                            state <= S_PARITY;
`else
                            state <= S_STOP;
`endif
                        end else begin
                            bit_cnt <= bit_cnt + 3'd1;
                        end
                    end else begin
                        baud_cnt <= baud_cnt - CW'(1);
                    end
                end
`ifdef UART_RX_PARITY_EN
                S_PARITY: begin
                    if (baud_tick) begin
                        par_bit  <= rxs;
                        baud_cnt <= CW'(CPB);
                        state    <= S_STOP;
                    end else begin
                        baud_cnt <= baud_cnt - CW'(1);
                    end
                end
`endif
                S_STOP: begin
                    if (baud_tick) begin
                        baud_cnt <= '0;
                        if (rxs) begin
                            state <= S_IDLE;
`ifdef UART_RX_PARITY_EN
                            if (^{shreg, par_bit} == 1'b0) begin
                                push      <= 1'b1;
                                push_data <= shreg;
                            end else begin
                                frame_err <= 1'b1;
                            end
`else
                            push      <= 1'b1;
                            push_data <= shreg;
`endif
                        end else begin
                            frame_err <= 1'b1;
                            state     <= S_BREAK;
                        end
                    end else begin
                        baud_cnt <= baud_cnt - CW'(1);
                    end
                end
                S_BREAK: begin
                    if (rxs) begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    logic [7:0]            mem [DEPTH];
    logic [DEPTH_LOG2-1:0] rd_ptr;
    logic [DEPTH_LOG2-1:0] wr_ptr;
    logic [NW-1:0]         count;
    logic                  pop;
    logic                  full;
    logic                  wr_en;
    logic                  overrun;

    assign pop   = FIFO_RD && (count != '0);
    assign full  = (count == NW'(DEPTH));
    // A pop on the same edge frees the slot, so a full FIFO still accepts.
    assign wr_en = push && (!full || pop);

    always_ff @(posedge CLK) begin
        if (RST_N && wr_en) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            count   <= '0;
            overrun <= 1'b0;
        end else begin
            overrun <= push && full && !pop;
            if (wr_en) begin
                wr_ptr <= wr_ptr + DEPTH_LOG2'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + DEPTH_LOG2'(1);
            end
            case ({wr_en, pop})
                2'b10:   count <= count + NW'(1);
                2'b01:   count <= count - NW'(1);
                default: count <= count;
            endcase
        end
    end

    assign FIFO_OUT  = (count != '0) ? mem[rd_ptr] : 8'h00;
    assign FIFO_V_N  = (count == '0);
    assign OVERRUN   = overrun;
    assign FRAME_ERR = frame_err;
endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb/tb_uart_rx_fifo.sv - Scoreboard bench for uart_rx_fifo with a queue-based FIFO model.
module tb_uart_rx_fifo;
    localparam int CPB   = 20;
    localparam int DEPTH = 16;

    logic       CLK = 1'b0;
    logic       RST_N = 1'b0;
    logic       RX = 1'b1;
    logic       FIFO_RD = 1'b0;
    logic [7:0] FIFO_OUT;
    logic       FIFO_V_N;
    logic       OVERRUN;
    logic       FRAME_ERR;

    int         n_cmp = 0;
    int         n_bad = 0;
    logic [7:0] exp_q[$];
    int         ovr_exp = 0;
    int         ovr_seen = 0;
    int         fe_exp = 0;
    int         fe_seen = 0;
    bit         done = 1'b0;

    always #5 CLK = ~CLK;

    uart_rx_fifo #(.CLK_HZ(1200000), .BAUD(60000), .DEPTH_LOG2(4)) dut (
        .CLK(CLK), .RST_N(RST_N), .RX(RX), .FIFO_OUT(FIFO_OUT), .FIFO_V_N(FIFO_V_N),
        .FIFO_RD(FIFO_RD), .OVERRUN(OVERRUN), .FRAME_ERR(FRAME_ERR)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    // Reference: a good frame enters the FIFO unless 16 bytes are already waiting.
    task automatic model_frame(input logic [7:0] d, input logic stop_ok, input logic par_ok);
        if (!stop_ok || !par_ok) fe_exp++;
        else if (exp_q.size() < DEPTH) exp_q.push_back(d);
        else ovr_exp++;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop, input logic flip, input int hold);
        logic par_ok;
        RX = 1'b0;
        tick(CPB);
        for (int i = 0; i < 8; i++) begin
            RX = d[i];
            tick(CPB);
        end
`ifdef UART_RX_PARITY_EN
        RX = (^d) ^ flip;
        tick(CPB);
        par_ok = !flip;
`else
        par_ok = 1'b1;
`endif
        model_frame(d, stop, par_ok);
        RX = stop;
        tick(CPB * (1 + hold));
        RX = 1'b1;
        if (!stop) tick(CPB);
    endtask

    task automatic pop();
        FIFO_RD = 1'b1;
        tick(1);
        FIFO_RD = 1'b0;
    endtask

    task automatic drain(input string name);
        for (int k = 0; k < 40 && exp_q.size() > 0; k++) pop();
        tick(1);
        check({name, "_left"}, exp_q.size(), 0);
        check({name, "_vn"}, FIFO_V_N, 1);
        check({name, "_out"}, FIFO_OUT, 0);
    endtask

    always @(negedge CLK) begin
        if (RST_N) begin
            if (OVERRUN === 1'b1) ovr_seen++;
            if (FRAME_ERR === 1'b1) fe_seen++;
            if (FIFO_RD === 1'b1 && FIFO_V_N === 1'b0) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL pop_unexpected: got %0h expected no data", FIFO_OUT);
                end else begin
                    check("pop_data", FIFO_OUT, exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] d;
        logic       s;
        logic       f;

        RST_N = 1'b0;
        tick(3);
        check("rst_vn", FIFO_V_N, 1);
        check("rst_out", FIFO_OUT, 0);
        check("rst_ovr", OVERRUN, 0);
        check("rst_fe", FRAME_ERR, 0);
        RST_N = 1'b1;
        tick(2);

        send_frame(8'hA5, 1'b1, 1'b0, 0);
        check("a5_vn", FIFO_V_N, 0);
        check("a5_out", FIFO_OUT, 8'hA5);
        drain("a5");

        send_frame(8'h81, 1'b1, 1'b0, 0);
        send_frame(8'h01, 1'b1, 1'b0, 0);
        pop();
        check("b2b_head", FIFO_OUT, 8'h01);
        drain("b2b");

        pop();
        check("rd_empty_vn", FIFO_V_N, 1);
        send_frame(8'h5A, 1'b1, 1'b0, 0);
        check("rd_empty_head", FIFO_OUT, 8'h5A);
        drain("rd_empty");

        for (int b = 0; b < 17; b++) send_frame(8'(b), 1'b1, 1'b0, 0);
        tick(4);
        check("ovr_count", ovr_seen, ovr_exp);
        check("ovr_head", FIFO_OUT, 8'h00);
        drain("ovr");

        RX = 1'b0;
        tick(CPB / 2 - 4);
        RX = 1'b1;
        tick(3 * CPB);
        check("glitch_vn", FIFO_V_N, 1);
        check("glitch_fe", fe_seen, fe_exp);
        send_frame(8'hC3, 1'b1, 1'b0, 0);
        drain("glitch");

        send_frame(8'h3C, 1'b0, 1'b0, 5);
        check("brk_fe", fe_seen, fe_exp);
        check("brk_vn", FIFO_V_N, 1);
        send_frame(8'h55, 1'b1, 1'b0, 0);
        drain("brk");

        send_frame(8'h11, 1'b1, 1'b0, 0);
        send_frame(8'h22, 1'b1, 1'b0, 0);
        send_frame(8'h33, 1'b1, 1'b0, 0);
        check("mid_pre_vn", FIFO_V_N, 0);
        d = 8'h96;
        RX = 1'b0;
        tick(CPB);
        for (int i = 0; i < 3; i++) begin
            RX = d[i];
            tick(CPB);
        end
        RX = d[3];
        tick(CPB / 2);
        RST_N = 1'b0;
        tick(1);
        RST_N = 1'b1;
        RX = 1'b1;
        exp_q.delete();
        check("mid_rst_vn", FIFO_V_N, 1);
        tick(12 * CPB);
        check("mid_after_vn", FIFO_V_N, 1);
        send_frame(8'h7E, 1'b1, 1'b0, 0);
        drain("mid");

`ifdef UART_RX_PARITY_EN
        send_frame(8'h07, 1'b1, 1'b1, 0);
        check("par_fe", fe_seen, fe_exp);
        check("par_vn", FIFO_V_N, 1);
`endif

        fork
            begin
                for (int k = 0; k < 24; k++) begin
                    d = 8'($urandom);
                    s = ($urandom_range(0, 7) != 0);
                    f = ($urandom_range(0, 5) == 0);
                    send_frame(d, s, f, s ? 0 : 1);
                end
                done = 1'b1;
            end
            begin
                while (!done) begin
                    FIFO_RD = ($urandom_range(0, 3) == 0);
                    tick(1);
                end
                FIFO_RD = 1'b0;
            end
        join
        drain("rand");
        check("final_fe", fe_seen, fe_exp);
        check("final_ovr", ovr_seen, ovr_exp);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
